bram_dual_req_frontend: RTL
===========================

// Module: bram_dual_req_frontend
// PURPOSE
//  Request/response front-end that drives both ports of the true dual-port block RAM.
//  - Turns two independent valid/ready request channels (A, B) into the RAM's ADDR/DI/WE/RE strobes.
//  - Returns read data on valid/ready response channels.
//  - Prevents same-address collisions, which make the RAM return X, by stalling port B.
//  - Sits between the core/cache memory clients and the RAM.
// PARAMETERS
//  ADDR_WIDTH  10  RAM address width; must match the RAM instance.
//  DATA_WIDTH  32  RAM data width; must match the RAM instance.
// PORTS
//  CLK          in   1     clock; all state updates on the rising edge
//  RST          in   1     reset; asynchronous, active-high
//  REQ_VALID_x  in   1     request valid, x in {A,B}
//  REQ_READY_x  out  1     request accepted this cycle when VALID & READY
//  REQ_WE_x     in   1     1 = write, 0 = read
//  REQ_ADDR_x   in   ADDR_WIDTH  request address
//  REQ_DATA_x   in   DATA_WIDTH  write data
//  RSP_VALID_x  out  1     read response valid
//  RSP_READY_x  in   1     response consumer ready
//  RSP_DATA_x   out  DATA_WIDTH  read data
//  ADDR_x / DI_x / WE_x / RE_x  out  RAM port strobes (ADDR_WIDTH / DATA_WIDTH / 1 / 1)
//  DO_x         in   DATA_WIDTH  RAM read data, valid the cycle after RE_x
//  CONFLICT_CNT out  16    saturating count of port-B conflict-stall cycles
// BEHAVIOUR
//  Reset (async, RST=1)
//   - Response FIFOs emptied, in-flight flags and CONFLICT_CNT cleared.
//   - RSP_VALID_x=0, REQ_READY_x=0, WE_x=0, RE_x=0 while RST is high.
//   - A read in flight when reset asserts is discarded; no response is ever produced for it.
//  Per-port state
//   - 2-entry response FIFO: occ_x in 0..2.
//   - In-flight flag infl_x: a read was issued last cycle.
//  Credit and request ready
//   - Reads need credit: occ_x + infl_x < 2. Writes need no credit.
//   - REQ_READY_A = !RST & (REQ_WE_A | credit_A).
//   - fire_A = REQ_VALID_A & REQ_READY_A.
//   - conflict = fire_A & REQ_VALID_B & (REQ_ADDR_A == REQ_ADDR_B) & (REQ_WE_A | REQ_WE_B).
//   - REQ_READY_B = !RST & (REQ_WE_B | credit_B) & !conflict.
//   - Port A always has priority. READY may depend on VALID/WE/ADDR; no path from RSP_READY to REQ_READY.
//  RAM drive (combinational)
//   - ADDR_x = REQ_ADDR_x, DI_x = REQ_DATA_x.
//   - WE_x = fire_x & REQ_WE_x, RE_x = fire_x & !REQ_WE_x.
//   - Two reads to the same address on A and B in one cycle are allowed and are not a conflict.
//  Read latency
//   - A read fired at edge t sets infl_x; DO_x is valid in cycle t+1.
//   - If occ_x == 0: bypass, RSP_DATA_x = DO_x and RSP_VALID_x = 1 in cycle t+1.
//     If RSP_READY_x is low, DO_x is pushed into the FIFO at edge t+1.
//   - If occ_x > 0: FIFO head is presented and DO_x is pushed at edge t+1, preserving order.
//   - Back-to-back reads with RSP_READY_x held high: one response per cycle, latency 1.
//  FIFO boundaries
//   - Push and pop in the same cycle leave occ_x unchanged.
//   - Overflow is impossible by credit. Pop on empty only happens via bypass.
//  CONFLICT_CNT
//   - +1 on every edge where conflict is 1.
//   - Saturates at 16'hFFFF; cleared only by reset.
// TESTING
//  1. Write A addr 5 = 0xDEADBEEF, then read B addr 5
//     -> RSP_VALID_B in the cycle after the read fires, RSP_DATA_B = 0xDEADBEEF.
//  2. Same cycle: A writes addr 7, B reads addr 7
//     -> REQ_READY_B = 0 for one cycle and CONFLICT_CNT = 1;
//        B fires the next cycle and returns the new data.
//  3. RSP_READY_A = 0; issue 3 reads on A
//     -> 2 accepted; REQ_READY_A = 0 for the 3rd until one response pops; responses in issue order.
//  4. 8 back-to-back reads on A and B with RSP_READY high -> 8 responses each, one per cycle, no gaps.
//  5. Assert RST the cycle after a read fires
//     -> RSP_VALID = 0 immediately; no stale response after reset releases.
//  6. Force 70000 conflict cycles -> CONFLICT_CNT holds at 0xFFFF.

Source files
------------

// File: rtl/bram_dual_req_frontend.sv
// Valid/ready front-end for a true dual-port block RAM: port A has priority,
// port B stalls on same-address collisions involving a write, 2-entry response FIFOs.
module bram_rsp_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_rd,
    input  logic [DATA_WIDTH-1:0] ram_do,
    input  logic                  rsp_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  credit
);
    logic [DATA_WIDTH-1:0] slot0_q, slot0_d, slot1_q, slot1_d, head_s;
    logic                  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  infl_q, infl_d;
    logic                  push_s, pop_s;

    // Response path: bypass RAM data when empty, otherwise present the FIFO head.
    always_comb begin
        credit = ({1'b0, occ_q} + {2'b00, infl_q}) < 3'd2;
        head_s = rd_ptr_q ? slot1_q : slot0_q;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (occ_q == 2'd0) begin
            rsp_valid = infl_q & ~rst;
            rsp_data  = ram_do;
            push_s    = infl_q & ~rsp_ready;
        end else begin
            rsp_valid = ~rst;
            rsp_data  = head_s;
            pop_s     = rsp_ready;
            push_s    = infl_q;
        end
        if (push_s && !pop_s) begin
            occ_d = occ_q + 2'd1;
        end else if (pop_s && !push_s) begin
            occ_d = occ_q - 2'd1;
        end else begin
            occ_d = occ_q;
        end
        wr_ptr_d = push_s ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop_s ? ~rd_ptr_q : rd_ptr_q;
        slot0_d  = (push_s && !wr_ptr_q) ? ram_do : slot0_q;
        slot1_d  = (push_s && wr_ptr_q) ? ram_do : slot1_q;
        infl_d   = issue_rd;
    end

    // Lane state; a read in flight at reset is simply forgotten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            infl_q   <= 1'b0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
        end
    end
endmodule

module bram_dual_req_frontend #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID_A,
    output logic                  REQ_READY_A,
    input  logic                  REQ_WE_A,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR_A,
    input  logic [DATA_WIDTH-1:0] REQ_DATA_A,
    output logic                  RSP_VALID_A,
    input  logic                  RSP_READY_A,
    output logic [DATA_WIDTH-1:0] RSP_DATA_A,
    output logic [ADDR_WIDTH-1:0] ADDR_A,
    output logic [DATA_WIDTH-1:0] DI_A,
    output logic                  WE_A,
    output logic                  RE_A,
    input  logic [DATA_WIDTH-1:0] DO_A,
    input  logic                  REQ_VALID_B,
    output logic                  REQ_READY_B,
    input  logic                  REQ_WE_B,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR_B,
    input  logic [DATA_WIDTH-1:0] REQ_DATA_B,
    output logic                  RSP_VALID_B,
    input  logic                  RSP_READY_B,
    output logic [DATA_WIDTH-1:0] RSP_DATA_B,
    output logic [ADDR_WIDTH-1:0] ADDR_B,
    output logic [DATA_WIDTH-1:0] DI_B,
    output logic                  WE_B,
    output logic                  RE_B,
    input  logic [DATA_WIDTH-1:0] DO_B,
    output logic [15:0]           CONFLICT_CNT
);
    logic        credit_a_s, credit_b_s, fire_a_s, fire_b_s, conflict_s;
    logic [15:0] cnt_q, cnt_d;

    // Request acceptance and RAM strobes; B yields whenever A touches the same word with a write.
    always_comb begin
        REQ_READY_A = ~RST & (REQ_WE_A | credit_a_s);
        fire_a_s    = REQ_VALID_A & REQ_READY_A;
        conflict_s  = fire_a_s & REQ_VALID_B & (REQ_ADDR_A == REQ_ADDR_B) & (REQ_WE_A | REQ_WE_B);
        REQ_READY_B = ~RST & (REQ_WE_B | credit_b_s) & ~conflict_s;
        fire_b_s    = REQ_VALID_B & REQ_READY_B;
        ADDR_A      = REQ_ADDR_A;
        DI_A        = REQ_DATA_A;
        WE_A        = fire_a_s & REQ_WE_A;
        RE_A        = fire_a_s & ~REQ_WE_A;
        ADDR_B      = REQ_ADDR_B;
        DI_B        = REQ_DATA_B;
        WE_B        = fire_b_s & REQ_WE_B;
        RE_B        = fire_b_s & ~REQ_WE_B;
        if (conflict_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Saturating conflict-stall counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CONFLICT_CNT = cnt_q;

    bram_rsp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_a (
        .clk(CLK), .rst(RST), .issue_rd(RE_A), .ram_do(DO_A), .rsp_ready(RSP_READY_A),
        .rsp_valid(RSP_VALID_A), .rsp_data(RSP_DATA_A), .credit(credit_a_s)
    );

    bram_rsp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane_b (
        .clk(CLK), .rst(RST), .issue_rd(RE_B), .ram_do(DO_B), .rsp_ready(RSP_READY_B),
        .rsp_valid(RSP_VALID_B), .rsp_data(RSP_DATA_B), .credit(credit_b_s)
    );
endmodule
